seq_booth_mult: RTL and testbench



---
 rtl/seq_booth_mult.sv | 129 ++++++++++++
 tb/tb_seq_booth_mult.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_booth_mult.sv
// Sequential signed Booth multiplier: low WIDTH bits of A*B plus an overflow flag.
// Build option SEQ_MULT_RADIX4_EN selects radix-4 (WIDTH/2 iterations) instead of radix-2 (WIDTH iterations).
module seq_booth_mult #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

`ifdef SEQ_MULT_RADIX4_EN
    localparam int HW   = WIDTH + 2;
    localparam int N    = WIDTH / 2;
    localparam int STEP = 2;
`else
    localparam int HW   = WIDTH + 1;
    localparam int N    = WIDTH;
    localparam int STEP = 1;
`endif
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [HW-1:0]    mcand_reg;
    logic [HW-1:0]    hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic             guard_reg;

    logic [HW-1:0]    addend;
    logic             cin;
    logic [HW-1:0]    sum;
    logic signed [HW+WIDTH:0] shifted;
    logic [HW-1:0]    hi_next;
    logic [WIDTH-1:0] lo_next;
    logic             guard_next;
    logic [WIDTH:0]   top_bits;
    logic             exc_next;

    // Booth recoding picks the addend; subtraction is ~M with carry-in so it shares the one adder.
    always_comb begin
        addend = '0;
        cin    = 1'b0;
`ifdef SEQ_MULT_RADIX4_EN
        case ({lo_reg[1:0], guard_reg})
            3'b001, 3'b010: addend = mcand_reg;
            3'b011:         addend = mcand_reg << 1;
            3'b100: begin
                addend = ~(mcand_reg << 1);
                cin    = 1'b1;
            end
            3'b101, 3'b110: begin
                addend = ~mcand_reg;
                cin    = 1'b1;
            end
            default: ;
        endcase
`else
        case ({lo_reg[0], guard_reg})
            2'b01: addend = mcand_reg;
            2'b10: begin
                addend = ~mcand_reg;
                cin    = 1'b1;
            end
            default: ;
        endcase
`endif
        sum        = hi_reg + addend + {{(HW-1){1'b0}}, cin};
        shifted    = $signed({sum, lo_reg, guard_reg}) >>> STEP;
        hi_next    = shifted[HW+WIDTH:WIDTH+1];
        lo_next    = shifted[WIDTH:1];
        guard_next = shifted[0];
        // Product fits in WIDTH bits only if bits [2W-1:W-1] are pure sign extension.
        top_bits   = {hi_next[WIDTH-1:0], lo_next[WIDTH-1]};
        exc_next   = !((&top_bits) || !(|top_bits));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            mcand_reg      <= '0;
            hi_reg         <= '0;
            lo_reg         <= '0;
            guard_reg      <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (ctrl_MULT) begin
                        mcand_reg <= {{(HW-WIDTH){data_operandA[WIDTH-1]}}, data_operandA};
                        hi_reg    <= '0;
                        lo_reg    <= data_operandB;
                        guard_reg <= 1'b0;
                        cnt_reg   <= '0;
                        state_reg <= RUN;
                    end
                end
                default: begin
                    hi_reg    <= hi_next;
                    lo_reg    <= lo_next;
                    guard_reg <= guard_next;
                    cnt_reg   <= cnt_reg + CW'(1);
                    if (cnt_reg == LAST) begin
                        data_result    <= lo_next;
                        data_exception <= exc_next;
                        data_resultRDY <= 1'b1;
                        state_reg      <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = (state_reg == RUN);

endmodule

// File: tb/tb_seq_booth_mult.sv
// Directed-vector bench for seq_booth_mult: table of products plus handshake/reset sequences.
module tb_seq_booth_mult;

`ifdef SEQ_MULT_RADIX4_EN
    localparam int N = 16;
`else
    localparam int N = 32;
`endif

    logic        clk;
    logic        rst_n;
    logic        ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] result;
    logic        exc;
    logic        rdy;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_r;
        logic        exp_e;
    } vec_t;

    vec_t vecs[11];

    seq_booth_mult #(.WIDTH(32)) dut (
        .clock          (clk),
        .reset_n        (rst_n),
        .ctrl_MULT      (ctrl),
        .data_operandA  (op_a),
        .data_operandB  (op_b),
        .data_result    (result),
        .data_exception (exc),
        .data_resultRDY (rdy),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Drive a start request now; returns just after the accepting edge.
    task automatic start_now(input logic [31:0] a, input logic [31:0] b);
        ctrl = 1'b1;
        op_a = a;
        op_b = b;
        @(posedge clk);
        #1;
        ctrl = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start_now(a, b);
    endtask

    // Count negedges until rdy; rdy is expected on the exp_lat-th, busy on all earlier ones.
    task automatic wait_done(input int exp_lat, input string nm);
        int k;
        int bcnt;
        bit seen;
        seen = 0;
        bcnt = 0;
        for (k = 1; k <= exp_lat + 8; k++) begin
            @(negedge clk);
            if (rdy) begin
                seen = 1;
                break;
            end
            if (busy) bcnt++;
        end
        if (!seen) k = exp_lat + 9;
        chk({nm, " latency"}, k, exp_lat);
        chk({nm, " busy_cycles"}, bcnt, exp_lat - 1);
        chk({nm, " busy_at_rdy"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic no_rdy_for(input int cyc, input string nm);
        int cnt;
        cnt = 0;
        for (int i = 0; i < cyc; i++) begin
            @(negedge clk);
            if (rdy) cnt++;
        end
        chk({nm, " spurious_rdy"}, cnt, 0);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input logic exp_e, input string nm);
        start(a, b);
        wait_done(N + 1, nm);
        chk({nm, " result"}, result, exp_r);
        chk({nm, " exception"}, {31'b0, exc}, {31'b0, exp_e});
        $display("op %s A=%h B=%h result=%h exc=%b", nm, a, b, result, exc);
        @(negedge clk);
        chk({nm, " rdy_one_cycle"}, {31'b0, rdy}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{32'd3,        32'hFFFFFFF9, 32'hFFFFFFEB, 1'b0};
        vecs[1]  = '{32'h7FFFFFFF, 32'd2,        32'hFFFFFFFE, 1'b1};
        vecs[2]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
        vecs[3]  = '{32'h80000000, 32'd1,        32'h80000000, 1'b0};
        vecs[4]  = '{32'd0,        32'd0,        32'd0,        1'b0};
        vecs[5]  = '{32'h80000000, 32'h80000000, 32'd0,        1'b1};
        vecs[6]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        1'b0};
        vecs[7]  = '{32'h12345678, 32'h10,       32'h23456780, 1'b1};
        vecs[8]  = '{32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, 1'b1};
        vecs[9]  = '{32'h00007FFF, 32'h00007FFF, 32'h3FFF0001, 1'b0};
        vecs[10] = '{32'd100,      32'hFFFFFF9C, 32'hFFFFD8F0, 1'b0};

        rst_n = 1'b0;
        ctrl  = 1'b1;
        op_a  = 32'd5;
        op_b  = 32'd5;
        repeat (3) @(negedge clk);
        chk("reset result", result, 32'd0);
        chk("reset exception", {31'b0, exc}, 32'd0);
        chk("reset rdy", {31'b0, rdy}, 32'd0);
        chk("reset busy", {31'b0, busy}, 32'd0);
        ctrl  = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp_r, vecs[i].exp_e, $sformatf("vec%0d", i));

        // ctrl held for three edges in IDLE starts one operation at the first edge.
        @(negedge clk);
        ctrl = 1'b1;
        op_a = 32'd7;
        op_b = 32'hFFFFFFFD;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        ctrl = 1'b0;
        wait_done(N - 1, "held");
        chk("held result", result, 32'hFFFFFFEB);
        $display("op held A=7 B=-3 result=%h exc=%b", result, exc);

        // Restart request mid-run is ignored; back-to-back start in the rdy cycle is accepted.
        start(32'd5, 32'd6);
        repeat (9) @(posedge clk);
        @(negedge clk);
        ctrl = 1'b1;
        op_a = 32'd9;
        op_b = 32'd9;
        @(posedge clk);
        #1;
        ctrl = 1'b0;
        op_a = 32'h1234;
        op_b = 32'h5678;
        wait_done(N - 9, "midrun");
        chk("midrun result", result, 32'd30);
        $display("op midrun A=5 B=6 result=%h exc=%b", result, exc);
        start_now(32'hFFFFFFFC, 32'hFFFFFFFC);
        wait_done(N + 1, "b2b");
        chk("b2b result", result, 32'd16);
        $display("op b2b A=-4 B=-4 result=%h exc=%b", result, exc);
        no_rdy_for(N + 4, "b2b_after");

        // Asynchronous reset mid-operation aborts with no completion pulse.
        start(32'd123, 32'd456);
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort result", result, 32'd0);
        chk("abort exception", {31'b0, exc}, 32'd0);
        chk("abort rdy", {31'b0, rdy}, 32'd0);
        chk("abort busy", {31'b0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        no_rdy_for(N + 4, "abort");
        $display("op abort A=123 B=456 result=%h busy=%b", result, busy);
        run_op(32'd2, 32'd3, 32'd6, 1'b0, "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
